// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b core types: the 16-bit word type and the memory-stage
// sequencer phase enum.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } mem_seq_phase_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LOW  = 2'b01;
  localparam logic [1:0] BE_HIGH = 2'b10;

endpackage

// File: rtl/mem_stage_sequencer_lane.sv
// Byte-lane helper: aligns the access address and produces the byte
// enables. Only a byte store keeps addr[0] and narrows the enables.
module mem_byte_lane
  import lc3b_types::*;
(
  input  lc3b_word   addr_i,
  input  logic       in_byte_i,
  output lc3b_word   aligned_addr_o,
  output logic [1:0] byte_enable_o
);

  // Address alignment and lane-enable decode
  always_comb begin
    aligned_addr_o = {addr_i[15:1], in_byte_i & addr_i[0]};
    if (in_byte_i) begin
      byte_enable_o = addr_i[0] ? BE_HIGH : BE_LOW;
    end else begin
      byte_enable_o = BE_WORD;
    end
  end

endmodule

// File: rtl/mem_stage_sequencer.sv
// Memory-stage access sequencer: single or two-phase (LDI/STI) data memory
// accesses with a pipeline stall. Optional counters under MEM_SEQ_PERF_EN.
module mem_stage_sequencer
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       ctrl_mem_read,
  input  logic       ctrl_mem_write,
  input  logic       ctrl_in_indirect,
  input  logic       ctrl_in_sti,
  input  logic       ctrl_in_byte,
  input  lc3b_word   req_addr,
  input  lc3b_word   req_wdata,
  input  logic       mem_resp,
  input  lc3b_word   mem_rdata,
  output logic       dmem_read,
  output logic       dmem_write,
  output lc3b_word   dmem_address,
  output lc3b_word   dmem_wdata,
  output logic [1:0] dmem_byte_enable,
  output lc3b_word   load_data,
  output logic       mem_stall,
  output logic       mem_done
`ifdef MEM_SEQ_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_accesses
`endif
);

  mem_seq_phase_t phase_q, phase_d;
  lc3b_word       ind_addr_q, ind_addr_d;
  logic           pending_s;
  logic           byte_store_s;
  lc3b_word       lane_addr_in_s, lane_addr_s;
  logic [1:0]     lane_be_s;

  // Gating with rst drops any request the instant reset asserts.
  assign pending_s    = req_valid & (ctrl_mem_read | ctrl_mem_write) & ~rst;
  assign byte_store_s = pending_s & ctrl_in_byte & ctrl_mem_write & ~ctrl_mem_read
                        & ~ctrl_in_indirect & (phase_q == FIRST);
  assign lane_addr_in_s = (phase_q == SECOND) ? ind_addr_q : req_addr;

  mem_byte_lane u_lane (
    .addr_i         (lane_addr_in_s),
    .in_byte_i      (byte_store_s),
    .aligned_addr_o (lane_addr_s),
    .byte_enable_o  (lane_be_s)
  );

  // Phase and pointer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= FIRST;
      ind_addr_q <= 16'h0000;
    end else begin
      phase_q    <= phase_d;
      ind_addr_q <= ind_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d    = phase_q;
    ind_addr_d = ind_addr_q;
    case (phase_q)
      FIRST: begin
        if (pending_s & ctrl_in_indirect & mem_resp) begin
          phase_d    = SECOND;
          ind_addr_d = {mem_rdata[15:1], 1'b0};
        end else begin
          phase_d = FIRST;
        end
      end
      SECOND: begin
        if (mem_resp) begin
          phase_d = FIRST;
        end else begin
          phase_d = SECOND;
        end
      end
      default: phase_d = FIRST;
    endcase
  end

  // Mealy request, handshake and stall outputs
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = 16'h0000;
    dmem_wdata       = 16'h0000;
    dmem_byte_enable = BE_WORD;
    load_data        = 16'h0000;
    mem_done         = 1'b0;
    case (phase_q)
      FIRST: begin
        if (pending_s) begin
          dmem_address     = lane_addr_s;
          dmem_byte_enable = lane_be_s;
          if (ctrl_in_indirect) begin
            dmem_read = 1'b1;
          end else begin
            dmem_read  = ctrl_mem_read;
            dmem_write = ctrl_mem_write & ~ctrl_mem_read;
          end
          mem_done = mem_resp & ~ctrl_in_indirect;
        end else begin
          mem_done = 1'b0;
        end
      end
      SECOND: begin
        dmem_address     = lane_addr_s;
        dmem_byte_enable = lane_be_s;
        if (ctrl_in_sti) begin
          dmem_write = 1'b1;
        end else begin
          dmem_read = 1'b1;
        end
        mem_done = mem_resp;
      end
      default: mem_done = 1'b0;
    endcase
    if (dmem_write) begin
      dmem_wdata = req_wdata;
    end else begin
      dmem_wdata = 16'h0000;
    end
    if (mem_done) begin
      load_data = mem_rdata;
    end else begin
      load_data = 16'h0000;
    end
    mem_stall = pending_s & ~mem_done;
  end

`ifdef MEM_SEQ_PERF_EN
  logic [31:0] perf_stall_q, perf_acc_q;

  // Free-running stall and access counters, wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_acc_q   <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_q + {31'd0, mem_stall};
      perf_acc_q   <= perf_acc_q + {31'd0, mem_resp & (dmem_read | dmem_write)};
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_accesses     = perf_acc_q;
`endif

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Self-checking bench for mem_stage_sequencer: scenario tasks with a
// scoreboard of expected completions popped on mem_done.
module tb_mem_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, ctrl_mem_read, ctrl_mem_write, ctrl_in_indirect;
  logic        ctrl_in_sti, ctrl_in_byte, mem_resp;
  logic [15:0] req_addr, req_wdata, mem_rdata;
  logic        dmem_read, dmem_write, mem_stall, mem_done;
  logic [15:0] dmem_address, dmem_wdata, load_data;
  logic [1:0]  dmem_byte_enable;
`ifdef MEM_SEQ_PERF_EN
  logic [31:0] perf_stall_cycles, perf_accesses;
`endif

  typedef struct {
    logic        is_store;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  mem_stage_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_write(ctrl_mem_write),
    .ctrl_in_indirect(ctrl_in_indirect), .ctrl_in_sti(ctrl_in_sti),
    .ctrl_in_byte(ctrl_in_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .load_data(load_data),
    .mem_stall(mem_stall), .mem_done(mem_done)
`ifdef MEM_SEQ_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_accesses(perf_accesses)
`endif
  );

  task automatic clear_req;
    req_valid = 1'b0; ctrl_mem_read = 1'b0; ctrl_mem_write = 1'b0;
    ctrl_in_indirect = 1'b0; ctrl_in_sti = 1'b0; ctrl_in_byte = 1'b0;
    req_addr = 16'h0000; req_wdata = 16'h0000;
    mem_resp = 1'b0; mem_rdata = 16'h0000;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_req();
    req_valid = 1'b1; ctrl_mem_read = 1'b1; req_addr = 16'h1234;
    @(negedge clk);
    n_vec++;
    if ({dmem_read, dmem_write, mem_stall, mem_done} !== 4'b0000) begin
      n_miss++;
      $display("FAIL reset_ctrl got %b want 0000", {dmem_read, dmem_write, mem_stall, mem_done});
    end
    n_vec++;
    if (dmem_address !== 16'h0000 || dmem_wdata !== 16'h0000 || load_data !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_data got addr=%h wdata=%h load=%h want 0", dmem_address, dmem_wdata, load_data);
    end
    n_vec++;
    if (dmem_byte_enable !== 2'b11) begin
      n_miss++;
      $display("FAIL reset_be got %b want 11", dmem_byte_enable);
    end
    next_cycle();
    rst = 1'b0;
    clear_req();
    next_cycle();
  endtask

  // Single word load answered lat cycles after the request.
  task automatic test_load(input logic [15:0] a, input int lat, input logic [15:0] d);
    exp_t e;
    int   stalls = 0;
    logic [15:0] exp_addr;
    exp_addr = {a[15:1], 1'b0};
    req_valid = 1'b1; ctrl_mem_read = 1'b1; req_addr = a;
    e.is_store = 1'b0; e.addr = exp_addr; e.data = d; e.be = 2'b11;
    sb.push_back(e);
    for (int i = 0; i <= lat; i++) begin
      mem_resp  = (i == lat);
      mem_rdata = (i == lat) ? d : 16'hDEAD;
      @(negedge clk);
      n_vec++;
      if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== exp_addr) begin
        n_miss++;
        $display("FAIL load_req cyc%0d got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=%h",
                 i, dmem_read, dmem_write, dmem_address, exp_addr);
      end
      if (mem_stall === 1'b1) stalls++;
      n_vec++;
      if (mem_done !== (i == lat)) begin
        n_miss++;
        $display("FAIL load_done cyc%0d got %b want %b", i, mem_done, (i == lat));
      end
      if (mem_done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (load_data !== e.data) begin
          n_miss++;
          $display("FAIL load_data got %h want %h", load_data, e.data);
        end
      end
      next_cycle();
    end
    n_vec++;
    if (stalls != lat) begin
      n_miss++;
      $display("FAIL load_stall_cycles got %0d want %0d", stalls, lat);
    end
    clear_req();
  endtask

  task automatic test_ldi;
    exp_t e;
    req_valid = 1'b1; ctrl_mem_read = 1'b1; ctrl_in_indirect = 1'b1; req_addr = 16'h2000;
    e.is_store = 1'b0; e.addr = 16'h3002; e.data = 16'h1234; e.be = 2'b11;
    sb.push_back(e);
    mem_resp = 1'b1; mem_rdata = 16'h3003;
    @(negedge clk);
    n_vec++;
    if (dmem_read !== 1'b1 || dmem_address !== 16'h2000 || mem_stall !== 1'b1 || mem_done !== 1'b0) begin
      n_miss++;
      $display("FAIL ldi_first got rd=%b addr=%h stall=%b done=%b want 1 2000 1 0",
               dmem_read, dmem_address, mem_stall, mem_done);
    end
    next_cycle();
    mem_resp = 1'b0; mem_rdata = 16'hDEAD;
    @(negedge clk);
    n_vec++;
    if (dmem_read !== 1'b1 || dmem_address !== 16'h3002 || mem_stall !== 1'b1 || mem_done !== 1'b0) begin
      n_miss++;
      $display("FAIL ldi_second_wait got rd=%b addr=%h stall=%b done=%b want 1 3002 1 0",
               dmem_read, dmem_address, mem_stall, mem_done);
    end
    next_cycle();
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    n_vec++;
    if (mem_done !== 1'b1 || mem_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL ldi_done got done=%b stall=%b want 1 0", mem_done, mem_stall);
    end
    if (mem_done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (load_data !== e.data || dmem_address !== e.addr) begin
        n_miss++;
        $display("FAIL ldi_data got data=%h addr=%h want %h %h", load_data, dmem_address, e.data, e.addr);
      end
    end
    next_cycle();
    clear_req();
  endtask

  task automatic test_sti;
    exp_t e;
    req_valid = 1'b1; ctrl_mem_read = 1'b1; ctrl_in_indirect = 1'b1; ctrl_in_sti = 1'b1;
    req_addr = 16'h2000; req_wdata = 16'h00AA;
    e.is_store = 1'b1; e.addr = 16'h4000; e.data = 16'h00AA; e.be = 2'b11;
    sb.push_back(e);
    mem_resp = 1'b1; mem_rdata = 16'h4001;
    @(negedge clk);
    n_vec++;
    if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== 16'h2000) begin
      n_miss++;
      $display("FAIL sti_first got rd=%b wr=%b addr=%h want 1 0 2000", dmem_read, dmem_write, dmem_address);
    end
    next_cycle();
    mem_resp = 1'b1; mem_rdata = 16'h0000;
    @(negedge clk);
    n_vec++;
    if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || mem_done !== 1'b1) begin
      n_miss++;
      $display("FAIL sti_second got wr=%b rd=%b done=%b want 1 0 1", dmem_write, dmem_read, mem_done);
    end
    if (mem_done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (dmem_address !== e.addr || dmem_wdata !== e.data || dmem_byte_enable !== e.be) begin
        n_miss++;
        $display("FAIL sti_store got addr=%h wdata=%h be=%b want %h %h %b",
                 dmem_address, dmem_wdata, dmem_byte_enable, e.addr, e.data, e.be);
      end
    end
    next_cycle();
    clear_req();
  endtask

  // Two byte stores issued back to back, each answered in its request cycle.
  task automatic test_back_to_back_stb;
    exp_t e;
    logic [15:0] addrs [2];
    logic [1:0]  bes   [2];
    addrs[0] = 16'h0011; bes[0] = 2'b10;
    addrs[1] = 16'h0010; bes[1] = 2'b01;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; ctrl_mem_write = 1'b1; ctrl_in_byte = 1'b1;
      req_addr = addrs[k]; req_wdata = 16'h5A5A; mem_resp = 1'b1;
      e.is_store = 1'b1; e.addr = addrs[k]; e.data = 16'h5A5A; e.be = bes[k];
      sb.push_back(e);
      @(negedge clk);
      n_vec++;
      if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || mem_stall !== 1'b0 || mem_done !== 1'b1) begin
        n_miss++;
        $display("FAIL stb%0d_ctrl got wr=%b rd=%b stall=%b done=%b want 1 0 0 1",
                 k, dmem_write, dmem_read, mem_stall, mem_done);
      end
      if (mem_done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (dmem_address !== e.addr || dmem_wdata !== e.data || dmem_byte_enable !== e.be) begin
          n_miss++;
          $display("FAIL stb%0d_store got addr=%h wdata=%h be=%b want %h %h %b",
                   k, dmem_address, dmem_wdata, dmem_byte_enable, e.addr, e.data, e.be);
        end
      end
      next_cycle();
    end
    clear_req();
  endtask

  task automatic test_reset_mid_access;
    req_valid = 1'b1; ctrl_mem_read = 1'b1; ctrl_in_indirect = 1'b1; req_addr = 16'h2000;
    mem_resp = 1'b1; mem_rdata = 16'h3003;
    next_cycle();
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    n_vec++;
    if (dmem_address !== 16'h3002 || dmem_read !== 1'b1) begin
      n_miss++;
      $display("FAIL rstmid_second got addr=%h rd=%b want 3002 1", dmem_address, dmem_read);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (dmem_read !== 1'b0 || mem_stall !== 1'b0 || mem_done !== 1'b0) begin
      n_miss++;
      $display("FAIL rstmid_drop got rd=%b stall=%b done=%b want 0 0 0", dmem_read, mem_stall, mem_done);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dmem_address !== 16'h2000 || dmem_read !== 1'b1 || mem_stall !== 1'b1) begin
      n_miss++;
      $display("FAIL rstmid_first got addr=%h rd=%b stall=%b want 2000 1 1", dmem_address, dmem_read, mem_stall);
    end
    next_cycle();
    clear_req();
    next_cycle();
  endtask

  task automatic test_no_mem_op;
`ifdef MEM_SEQ_PERF_EN
    logic [31:0] ps0, pa0;
    ps0 = perf_stall_cycles; pa0 = perf_accesses;
`endif
    req_valid = 1'b1; req_addr = 16'h1111; mem_resp = 1'b1; mem_rdata = 16'hFACE;
    @(negedge clk);
    n_vec++;
    if ({dmem_read, dmem_write, mem_stall, mem_done} !== 4'b0000 || load_data !== 16'h0000) begin
      n_miss++;
      $display("FAIL add_idle got ctrl=%b load=%h want 0000 0000",
               {dmem_read, dmem_write, mem_stall, mem_done}, load_data);
    end
    next_cycle();
`ifdef MEM_SEQ_PERF_EN
    n_vec++;
    if (perf_stall_cycles !== ps0 || perf_accesses !== pa0) begin
      n_miss++;
      $display("FAIL add_perf got %0d %0d want %0d %0d", perf_stall_cycles, perf_accesses, ps0, pa0);
    end
`endif
    clear_req();
  endtask

  task automatic test_random_loads;
    for (int n = 0; n < 6; n++) begin
      test_load(16'($urandom()), int'($urandom_range(0, 3)), 16'($urandom()));
    end
  endtask

  initial begin
    test_reset();
    test_load(16'h1004, 2, 16'hBEEF);
    test_load(16'h0ACE, 0, 16'h7777);
    test_ldi();
    test_sti();
    test_back_to_back_stb();
    test_reset_mid_access();
    test_no_mem_op();
    test_random_loads();
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
